vr_prepare_ok_tx: RTL and testbench
===================================

Name: vr_prepare_ok_tx

Overview:
Transmit-side serializer for VR PrepareOK replies, the counterpart of the Prepare receive path. Takes one PrepareOK request (view, opnum, replica index, last committed, destination tuple) from the replica state machine and builds the beehive header plus the PrepareOK header. It emits a UDP-TX metadata beat, then the big-endian header bytes as DATA_W-wide beats with last/padbytes toward the UDP transmit engine.

Parameters:
DATA_W, 256, output data width in bits; legal values 128, 256, 512.
PADBYTES_W, $clog2(DATA_W/8), width of padbytes field.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_val  in  1  request valid
req_view  in  INT_W  current view
req_opnum  in  INT_W  op number being acknowledged
req_rep_index  in  INT_W  this replica's index
req_last_commit  in  INT_W  last committed op
req_dst  in  MACHINE_TUPLE_W  destination ip/port (machine_tuple)
req_rdy  out  1  request accepted when req_val & req_rdy
tx_meta_val  out  1  metadata valid
tx_meta_dst  out  MACHINE_TUPLE_W  destination tuple
tx_meta_len  out  16  UDP payload length in bytes
tx_meta_rdy  in  1  metadata accepted
tx_data_val  out  1  data beat valid
tx_data  out  DATA_W  data beat, first byte on wire in MSBs
tx_data_last  out  1  final beat of message
tx_data_padbytes  out  PADBYTES_W  invalid low-order bytes on last beat, 0 otherwise
tx_data_rdy  in  1  data beat accepted

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high. On reset: state IDLE, req_rdy=1, tx_meta_val=0, tx_data_val=0, tx_data_last=0, tx_data_padbytes=0, tx_data=0, beat counter=0, message register=0.
- Message image (360 bits, 45 bytes) is built at acceptance and stored in one register: beehive_hdr {frag_num=NONFRAG_MAGIC, msg_type=PrepareOK (8'd6), msg_len=PREPARE_OK_HDR_BYTES (32)} concatenated MSB-first with prepare_ok_hdr {view, opnum, rep_index, last_committed}. tx_meta_len = BEEHIVE_HDR_BYTES + PREPARE_OK_HDR_BYTES = 45.
- NUM_BEATS = ceil(360/DATA_W): 128→3, 256→2, 512→1. Last-beat valid bytes = 45 - (NUM_BEATS-1)*DATA_W/8. padbytes = DATA_W/8 - that count: 128→3, 256→19, 512→19. Unused low bits of the last beat are driven 0.
- States:
  - IDLE: req_rdy=1. On req_val, capture and go to META.
  - META: tx_meta_val=1. On tx_meta_rdy, go to DATA with beat counter=0.
  - DATA: tx_data_val=1, tx_data = beat[counter], where beat k is image bits [359-k*DATA_W -: DATA_W], zero-extended. tx_data_last=1 when counter==NUM_BEATS-1. On tx_data_rdy: if last, go to IDLE; else counter+1.
- Latency: tx_meta_val asserts the cycle after acceptance; the first data beat asserts the cycle after the meta handshake. There is no bubble between data beats under continuous rdy. Throughput is one message per NUM_BEATS+2 cycles.
- The block never accepts a new request until the last data beat handshakes; req_rdy is 0 in META/DATA. A new request can be accepted in the cycle after the last-beat handshake.
- Outputs stay stable while val=1 and rdy=0 (AXI-style; val is never dropped without a handshake).
- Reset mid-message: the message is discarded, all outputs return to reset values immediately, and no partial message is resumed.
- No arithmetic on field values; they are passed through verbatim, full 64-bit.

Optional Feature:
VR_PREPARE_OK_TX_STATS_EN — when defined, adds output msgs_sent (COUNT_W, reset 0), incremented on each last-beat handshake and wrapping at 2^COUNT_W. It also adds output stall_cycles (32 bits, reset 0, saturating at all-ones), incremented each cycle tx_meta_val or tx_data_val is high with the matching rdy low. When undefined, neither port nor register exists and behaviour is otherwise identical.

Decomposition:
- beehive_vr_pkg already provides beehive_hdr, prepare_ok_hdr, msg_type, machine_tuple, NONFRAG_MAGIC, and the *_BYTES constants.
- Add PREPARE_OK_MSG_BYTES (45) and a packed typedef prepare_ok_msg = {beehive_hdr, prepare_ok_hdr} to the package.
- One natural sub-module: vr_hdr_beat_mux (combinational beat select plus padbytes/last generation, parameterized on image width and DATA_W), reusable by future Commit/StartView transmitters.

Test Plan:
- DATA_W=256, request view=3, opnum=0x10, rep_index=1, last_commit=0xF, dst=10.0.0.2:51000, rdy held high → meta len=45 one cycle after accept.
  - Beat0 MSBs = 0x18030520_06_0000000000000020_…; beat1 last=1, padbytes=19, low 152 bits zero.
- Backpressure: tx_data_rdy low for 5 cycles on beat0 → beat0 held stable, no beat1, req_rdy=0 throughout.
- Back-to-back: req_val held high with two distinct requests → second accepted exactly the cycle after the first last-beat handshake; its meta follows with correct fields.
- DATA_W=128 and DATA_W=512 builds → 3 beats/padbytes=3 and 1 beat/padbytes=19 respectively, with byte images matching the 256 case.
- Assert rst during beat1 wait → all val low immediately; after release req_rdy=1 and the next message is sent complete and correct.
- With VR_PREPARE_OK_TX_STATS_EN: 4 messages, meta stalled 2 cycles each → msgs_sent=4, stall_cycles=8.

Source files
------------

// File: rtl/vr_prepare_ok_tx_pkg.sv
// Shared beehive/VR message definitions for the PrepareOK transmit path.
//   - Beehive header: frag_num (32b), msg_type (8b), msg_len (64b) = 13 bytes.
//   - PrepareOK header: view, opnum, rep_index, last_committed (64b each) = 32 bytes.
//   - prepare_ok_msg packs the two headers MSB-first, i.e. the 45-byte wire image.
//   - machine_tuple is the destination ip/port used for UDP-TX metadata.
package vr_prepare_ok_tx_pkg;

   localparam int INT_W                = 64;
   localparam int MACHINE_TUPLE_W      = 48;
   localparam logic [31:0] NONFRAG_MAGIC = 32'h1803_0520;
   localparam int BEEHIVE_HDR_BYTES    = 13;
   localparam int PREPARE_OK_HDR_BYTES = 32;
   localparam int PREPARE_OK_MSG_BYTES = BEEHIVE_HDR_BYTES + PREPARE_OK_HDR_BYTES;
   localparam int PREPARE_OK_MSG_W     = PREPARE_OK_MSG_BYTES * 8;

   typedef enum logic [7:0] {
      MSG_PREPARE    = 8'd5,
      MSG_PREPARE_OK = 8'd6,
      MSG_COMMIT     = 8'd7
   } msg_type_e;

   typedef struct packed {
      logic [31:0] ip_addr;
      logic [15:0] port;
   } machine_tuple;

   typedef struct packed {
      logic [31:0] frag_num;
      msg_type_e   msg_type;
      logic [63:0] msg_len;
   } beehive_hdr;

   typedef struct packed {
      logic [INT_W-1:0] view;
      logic [INT_W-1:0] opnum;
      logic [INT_W-1:0] rep_index;
      logic [INT_W-1:0] last_committed;
   } prepare_ok_hdr;

   typedef struct packed {
      beehive_hdr    bh;
      prepare_ok_hdr ok;
   } prepare_ok_msg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_META = 2'd1,
      ST_DATA = 2'd2
   } tx_state_e;

   function automatic prepare_ok_msg build_prepare_ok(
      input logic [INT_W-1:0] view,
      input logic [INT_W-1:0] opnum,
      input logic [INT_W-1:0] rep_index,
      input logic [INT_W-1:0] last_committed
   );
      prepare_ok_msg m;
      m.bh.frag_num       = NONFRAG_MAGIC;
      m.bh.msg_type       = MSG_PREPARE_OK;
      m.bh.msg_len        = 64'(PREPARE_OK_HDR_BYTES);
      m.ok.view           = view;
      m.ok.opnum          = opnum;
      m.ok.rep_index      = rep_index;
      m.ok.last_committed = last_committed;
      return m;
   endfunction

endpackage

// File: rtl/vr_hdr_beat_mux.sv
// Combinational beat selector for a fixed-size header image.
// Splits an IMG_W-bit image (first wire byte in the MSBs) into DATA_W-wide
// beats, zero-filling the tail of the final beat, and flags last/padbytes.
// Ports:
//   img           in   IMG_W       message image, MSB = first byte on wire
//   beat_idx      in   IDX_W       beat number to present
//   beat_data     out  DATA_W      selected beat
//   beat_last     out  1           beat_idx is the final beat
//   beat_padbytes out  PADBYTES_W  invalid low bytes of the final beat, else 0
module vr_hdr_beat_mux #(
   parameter int IMG_W      = 360,
   parameter int DATA_W     = 256,
   parameter int PADBYTES_W = $clog2(DATA_W/8),
   parameter int NUM_BEATS  = (IMG_W + DATA_W - 1) / DATA_W,
   parameter int IDX_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
   input  logic [IMG_W-1:0]      img,
   input  logic [IDX_W-1:0]      beat_idx,
   output logic [DATA_W-1:0]     beat_data,
   output logic                  beat_last,
   output logic [PADBYTES_W-1:0] beat_padbytes
);

   localparam int TOT_W      = NUM_BEATS * DATA_W;
   localparam int LAST_BYTES = IMG_W/8 - (NUM_BEATS-1)*(DATA_W/8);
   localparam int PAD_BYTES  = DATA_W/8 - LAST_BYTES;

   logic [TOT_W-1:0] img_left;
   logic [TOT_W-1:0] img_shift;

   always_comb begin
      // left-justify so the unused tail of the final beat reads as zero
      img_left      = TOT_W'(img) << (TOT_W - IMG_W);
      img_shift     = img_left << (int'(beat_idx) * DATA_W);
      beat_data     = img_shift[TOT_W-1 -: DATA_W];
      beat_last     = (int'(beat_idx) == NUM_BEATS - 1);
      beat_padbytes = beat_last ? PADBYTES_W'(PAD_BYTES) : '0;
   end

endmodule

// File: rtl/vr_prepare_ok_tx.sv
// VR PrepareOK transmit serializer. Captures one request, emits a UDP-TX
// metadata beat, then the 45-byte big-endian header image as DATA_W beats.
// Optional macro VR_PREPARE_OK_TX_STATS_EN adds msgs_sent / stall_cycles.
// Ports:
//   clk, rst (async, active-high)
//   req_val/req_rdy + req_view/req_opnum/req_rep_index/req_last_commit/req_dst
//   tx_meta_val/tx_meta_rdy + tx_meta_dst/tx_meta_len
//   tx_data_val/tx_data_rdy + tx_data/tx_data_last/tx_data_padbytes
//   [stats] msgs_sent (COUNT_W, wraps), stall_cycles (32b, saturates)
//
// state   | meaning
// IDLE    | ready for a request
// META    | presenting UDP-TX metadata
// DATA    | presenting header beat cnt_q
module vr_prepare_ok_tx
   import vr_prepare_ok_tx_pkg::*;
#(
   parameter int DATA_W     = 256,
   parameter int PADBYTES_W = $clog2(DATA_W/8)
`ifdef VR_PREPARE_OK_TX_STATS_EN
   ,parameter int COUNT_W   = 16
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_val,
   input  logic [INT_W-1:0]           req_view,
   input  logic [INT_W-1:0]           req_opnum,
   input  logic [INT_W-1:0]           req_rep_index,
   input  logic [INT_W-1:0]           req_last_commit,
   input  logic [MACHINE_TUPLE_W-1:0] req_dst,
   output logic                       req_rdy,
   output logic                       tx_meta_val,
   output logic [MACHINE_TUPLE_W-1:0] tx_meta_dst,
   output logic [15:0]                tx_meta_len,
   input  logic                       tx_meta_rdy,
   output logic                       tx_data_val,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       tx_data_last,
   output logic [PADBYTES_W-1:0]      tx_data_padbytes,
   input  logic                       tx_data_rdy
`ifdef VR_PREPARE_OK_TX_STATS_EN
   ,output logic [COUNT_W-1:0]        msgs_sent
   ,output logic [31:0]               stall_cycles
`endif
);

   localparam int NUM_BEATS = (PREPARE_OK_MSG_W + DATA_W - 1) / DATA_W;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   tx_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   prepare_ok_msg msg_q, msg_d;
   machine_tuple  dst_q, dst_d;

   logic [DATA_W-1:0]     beat_data;
   logic                  beat_last;
   logic [PADBYTES_W-1:0] beat_padbytes;

   vr_hdr_beat_mux #(
      .IMG_W      (PREPARE_OK_MSG_W),
      .DATA_W     (DATA_W),
      .PADBYTES_W (PADBYTES_W),
      .NUM_BEATS  (NUM_BEATS),
      .IDX_W      (CNT_W)
   ) u_beat_mux (
      .img           (msg_q),
      .beat_idx      (cnt_q),
      .beat_data     (beat_data),
      .beat_last     (beat_last),
      .beat_padbytes (beat_padbytes)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      msg_d       = msg_q;
      dst_d       = dst_q;
      req_rdy     = 1'b0;
      tx_meta_val = 1'b0;
      tx_data_val = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_rdy = 1'b1;
            if (req_val) begin
               msg_d   = build_prepare_ok(req_view, req_opnum, req_rep_index, req_last_commit);
               dst_d   = req_dst;
               state_d = ST_META;
            end
         end
         ST_META: begin
            tx_meta_val = 1'b1;
            if (tx_meta_rdy) begin
               cnt_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_data_val = 1'b1;
            if (tx_data_rdy) begin
               if (beat_last) state_d = ST_IDLE;
               else           cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         msg_q   <= '0;
         dst_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         dst_q   <= dst_d;
      end
   end

   // data outputs are forced to zero outside DATA so a reset or idle bus is quiet
   assign tx_data          = tx_data_val ? beat_data : '0;
   assign tx_data_last     = tx_data_val & beat_last;
   assign tx_data_padbytes = tx_data_val ? beat_padbytes : '0;
   assign tx_meta_dst      = dst_q;
   assign tx_meta_len      = 16'(PREPARE_OK_MSG_BYTES);

`ifdef VR_PREPARE_OK_TX_STATS_EN
   logic [COUNT_W-1:0] msgs_sent_q, msgs_sent_d;
   logic [31:0]        stall_q, stall_d;

   always_comb begin
      msgs_sent_d = msgs_sent_q;
      stall_d     = stall_q;
      if (tx_data_val && tx_data_rdy && beat_last)
         msgs_sent_d = msgs_sent_q + COUNT_W'(1);
      if (((tx_meta_val && !tx_meta_rdy) || (tx_data_val && !tx_data_rdy)) && (stall_q != '1))
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msgs_sent_q <= '0;
         stall_q     <= '0;
      end else begin
         msgs_sent_q <= msgs_sent_d;
         stall_q     <= stall_d;
      end
   end

   assign msgs_sent    = msgs_sent_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vr_prepare_ok_tx.sv
`timescale 1ns/1ps
module tb_vr_prepare_ok_tx;
   import vr_prepare_ok_tx_pkg::*;

   localparam int DW        = 256;
   localparam int PW        = $clog2(DW/8);
   localparam int DB        = DW/8;
   localparam int EXP_BEATS = (DW == 128) ? 3 : (DW == 256) ? 2 : 1;
   localparam int EXP_PAD   = (DW == 128) ? 3 : 19;
   localparam int COUNT_W   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_val;
   logic [63:0]   req_view, req_opnum, req_rep_index, req_last_commit;
   logic [47:0]   req_dst;
   logic          req_rdy;
   logic          tx_meta_val;
   logic [47:0]   tx_meta_dst;
   logic [15:0]   tx_meta_len;
   logic          tx_meta_rdy;
   logic          tx_data_val;
   logic [DW-1:0] tx_data;
   logic          tx_data_last;
   logic [PW-1:0] tx_data_padbytes;
   logic          tx_data_rdy;
`ifdef VR_PREPARE_OK_TX_STATS_EN
   logic [COUNT_W-1:0] msgs_sent;
   logic [31:0]        stall_cycles;
`endif

   vr_prepare_ok_tx #(
      .DATA_W     (DW),
      .PADBYTES_W (PW)
`ifdef VR_PREPARE_OK_TX_STATS_EN
      ,.COUNT_W   (COUNT_W)
`endif
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_val          (req_val),
      .req_view         (req_view),
      .req_opnum        (req_opnum),
      .req_rep_index    (req_rep_index),
      .req_last_commit  (req_last_commit),
      .req_dst          (req_dst),
      .req_rdy          (req_rdy),
      .tx_meta_val      (tx_meta_val),
      .tx_meta_dst      (tx_meta_dst),
      .tx_meta_len      (tx_meta_len),
      .tx_meta_rdy      (tx_meta_rdy),
      .tx_data_val      (tx_data_val),
      .tx_data          (tx_data),
      .tx_data_last     (tx_data_last),
      .tx_data_padbytes (tx_data_padbytes),
      .tx_data_rdy      (tx_data_rdy)
`ifdef VR_PREPARE_OK_TX_STATS_EN
      ,.msgs_sent       (msgs_sent)
      ,.stall_cycles    (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [PW-1:0] pad;
   } beat_t;

   typedef struct {
      logic [47:0] dst;
      logic [15:0] len;
   } meta_t;

   beat_t data_q[$];
   meta_t meta_q[$];
   int    checks      = 0;
   int    failures    = 0;
   int    last_hs_cyc = -1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // wire image: magic, type 6, msg_len 32, then the four 64-bit fields
   function automatic logic [359:0] img_of(input logic [63:0] v, input logic [63:0] o,
                                           input logic [63:0] r, input logic [63:0] l);
      return {32'h1803_0520, 8'h06, 64'd32, v, o, r, l};
   endfunction

   task automatic push_expect(input logic [63:0] v, input logic [63:0] o, input logic [63:0] r,
                              input logic [63:0] l, input logic [47:0] d);
      logic [359:0] img;
      meta_t        m;
      beat_t        b;
      img   = img_of(v, o, r, l);
      m.dst = d;
      m.len = 16'd45;
      meta_q.push_back(m);
      for (int k = 0; k < EXP_BEATS; k++) begin
         b.data = '0;
         for (int j = 0; j < DB; j++) begin
            int gi;
            gi = k*DB + j;
            if (gi < 45) b.data[DW-1-8*j -: 8] = img[359-8*gi -: 8];
         end
         b.last = (k == EXP_BEATS-1);
         b.pad  = b.last ? PW'(EXP_PAD) : '0;
         data_q.push_back(b);
      end
   endtask

   // monitor: pops the scoreboard on every output handshake
   meta_t mon_m;
   beat_t mon_b;
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_meta_val && tx_meta_rdy) begin
            if (meta_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL meta_unexpected actual=%0h required=none", tx_meta_dst);
            end else begin
               mon_m = meta_q.pop_front();
               chk("meta_dst", 512'(tx_meta_dst), 512'(mon_m.dst));
               chk("meta_len", 512'(tx_meta_len), 512'(mon_m.len));
            end
         end
         if (tx_data_val && tx_data_rdy) begin
            if (data_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL data_unexpected actual=%0h required=none", tx_data);
            end else begin
               mon_b = data_q.pop_front();
               chk("beat_data", 512'(tx_data), 512'(mon_b.data));
               chk("beat_last", 512'(tx_data_last), 512'(mon_b.last));
               chk("beat_pad", 512'(tx_data_padbytes), 512'(mon_b.pad));
            end
            if (tx_data_last) last_hs_cyc = cyc + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] v, input logic [63:0] o, input logic [63:0] r,
                       input logic [63:0] l, input logic [47:0] d, output int acc_cyc);
      int n;
      req_val         = 1'b1;
      req_view        = v;
      req_opnum       = o;
      req_rep_index   = r;
      req_last_commit = l;
      req_dst         = d;
      push_expect(v, o, r, l, d);
      n = 0;
      while (!req_rdy && n < 200) begin
         step();
         n++;
      end
      if (!req_rdy) fail_now("req_accept");
      step();
      acc_cyc = cyc;
      req_val = 1'b0;
      chk("meta_latency", 512'(tx_meta_val), 512'(1));
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((meta_q.size() != 0 || data_q.size() != 0 || !req_rdy) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) fail_now(name);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int acc_a, acc_b;
      logic [DW-1:0] held;

      rst = 1'b1; req_val = 1'b0;
      req_view = '0; req_opnum = '0; req_rep_index = '0; req_last_commit = '0; req_dst = '0;
      tx_meta_rdy = 1'b1; tx_data_rdy = 1'b1;
      step(); step();
      chk("rst_req_rdy", 512'(req_rdy), 512'(1));
      chk("rst_meta_val", 512'(tx_meta_val), 512'(0));
      chk("rst_data_val", 512'(tx_data_val), 512'(0));
      chk("rst_data", 512'(tx_data), 512'(0));
      chk("rst_last_pad", 512'({tx_data_last, tx_data_padbytes}), 512'(0));
      rst = 1'b0;
      step();

      // meta held off two cycles on each of four messages
      for (int i = 0; i < 4; i++) begin
         tx_meta_rdy = 1'b0;
         send(64'd100 + 64'(i), 64'd200 + 64'(i), 64'd2, 64'd50 + 64'(i), 48'hC0A8_0101_1F90, acc_a);
         step(); step();
         tx_meta_rdy = 1'b1;
         wait_idle("stall_drain");
      end
`ifdef VR_PREPARE_OK_TX_STATS_EN
      chk("msgs_sent", 512'(msgs_sent), 512'(4));
      chk("stall_cycles", 512'(stall_cycles), 512'(8));
`endif

      // basic message with continuous ready
      send(64'd3, 64'h10, 64'd1, 64'hF, 48'h0A00_0002_C738, acc_a);
      step();
      chk("data_latency", 512'(tx_data_val), 512'(1));
      chk("beat0_hdr", 512'(tx_data[DW-1 -: 104]), 512'(104'h18030520_06_0000000000000020));
      wait_idle("basic_drain");

      // full-width field pass-through
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001,
           64'hDEAD_BEEF_CAFE_F00D, 48'hFFFF_FFFF_FFFF, acc_a);
      wait_idle("wide_drain");

      // data backpressure on beat 0
      tx_data_rdy = 1'b0;
      send(64'd7, 64'd8, 64'd9, 64'd10, 48'h0A00_0003_0050, acc_a);
      step(); step();
      held = tx_data;
      for (int i = 0; i < 5; i++) begin
         chk("bp_val", 512'(tx_data_val), 512'(1));
         chk("bp_stable", 512'(tx_data), 512'(held));
         chk("bp_last", 512'(tx_data_last), 512'(EXP_BEATS == 1));
         chk("bp_req_rdy", 512'(req_rdy), 512'(0));
         step();
      end
      tx_data_rdy = 1'b1;
      wait_idle("bp_drain");

      // back-to-back requests
      send(64'h11, 64'h22, 64'h33, 64'h44, 48'h0A00_0004_1111, acc_a);
      send(64'h55, 64'h66, 64'h77, 64'h88, 48'h0A00_0005_2222, acc_b);
      chk("b2b_accept", 512'(acc_b), 512'(last_hs_cyc + 1));
      wait_idle("b2b_drain");

      // reset while the final beat is waiting
      tx_data_rdy = 1'b0;
      send(64'hAA, 64'hBB, 64'hCC, 64'hDD, 48'h0A00_0006_3333, acc_a);
      step(); step();
      for (int k = 0; k < EXP_BEATS-1; k++) begin
         tx_data_rdy = 1'b1;
         step();
         tx_data_rdy = 1'b0;
      end
      chk("pre_rst_last", 512'(tx_data_last), 512'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_data_val", 512'(tx_data_val), 512'(0));
      chk("mid_rst_meta_val", 512'(tx_meta_val), 512'(0));
      chk("mid_rst_data", 512'(tx_data), 512'(0));
      data_q.delete();
      meta_q.delete();
      step();
      rst = 1'b0;
      tx_data_rdy = 1'b1;
      step();
      chk("post_rst_req_rdy", 512'(req_rdy), 512'(1));
      send(64'd3, 64'h10, 64'd1, 64'hF, 48'h0A00_0002_C738, acc_a);
      wait_idle("post_rst_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
